// File: rtl/atm_dispense_pkg.sv
// Shared status codes and state encodings for the ATM dispense sequencer and its note planner.
// Codes are kept as plain localparams so legacy tooling can read them.
package atm_dispense_pkg;

   typedef logic [2:0] status_t;
   typedef logic [2:0] state_t;
   typedef logic [1:0] phase_t;

   localparam status_t ST_OK           = 3'd0;
   localparam status_t ST_BAD_AMOUNT   = 3'd1;
   localparam status_t ST_INSUFFICIENT = 3'd2;
   localparam status_t ST_TOO_MANY     = 3'd3;
   localparam status_t ST_JAM          = 3'd4;
   localparam status_t ST_ABORTED      = 3'd5;

   // Sequencer states; PLAN covers the planner's HI/LO/CHECK phases.
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_PLAN = 3'd1;
   localparam state_t S_PICK = 3'd2;
   localparam state_t S_WAIT = 3'd3;
   localparam state_t S_ERR  = 3'd4;
   localparam state_t S_DONE = 3'd5;

   localparam phase_t P_IDLE  = 2'd0;
   localparam phase_t P_HI    = 2'd1;
   localparam phase_t P_LO    = 2'd2;
   localparam phase_t P_CHECK = 2'd3;

endpackage

// File: rtl/atm_dispense_sequencer_if.sv
// Controller/dispenser bundle: withdrawal handshake, cassette levels, pick/sense and result.
// The controller side is the master; the sequencer is the slave.
interface atm_dispense_sequencer_if #(
   parameter int AMT_W = 16,
   parameter int CNT_W = 8
);
   logic             req_valid;
   logic             req_ready;
   logic [AMT_W-1:0] req_amount;
   logic             abort;
   logic [CNT_W-1:0] cass_hi_level;
   logic [CNT_W-1:0] cass_lo_level;
   logic             pick_hi;
   logic             pick_lo;
   logic             note_sensed;
   logic             busy;
   logic             done;
   logic [2:0]       status;
   logic [CNT_W-1:0] notes_hi;
   logic [CNT_W-1:0] notes_lo;

   modport master (
      output req_valid, req_amount, abort, cass_hi_level, cass_lo_level, note_sensed,
      input  req_ready, pick_hi, pick_lo, busy, done, status, notes_hi, notes_lo
   );

   modport slave (
      input  req_valid, req_amount, abort, cass_hi_level, cass_lo_level, note_sensed,
      output req_ready, pick_hi, pick_lo, busy, done, status, notes_hi, notes_lo
   );
endinterface

// File: rtl/atm_note_planner.sv
// Iterative note-mix planner: one subtraction per cycle, high denomination first, then a
// one-cycle CHECK where o_plan_done pulses with the plan and its verdict.
module atm_note_planner
   import atm_dispense_pkg::*;
#(
   parameter int AMT_W     = 16,
   parameter int CNT_W     = 8,
   parameter int DENOM_HI  = 500,
   parameter int DENOM_LO  = 100,
   parameter int MAX_NOTES = 40
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_clear,
   input  logic [AMT_W-1:0] i_amount,
   input  logic [CNT_W-1:0] i_lvl_hi,
   input  logic [CNT_W-1:0] i_lvl_lo,
   output logic [CNT_W-1:0] o_plan_hi,
   output logic [CNT_W-1:0] o_plan_lo,
   output logic             o_plan_done,
   output status_t          o_plan_status
);
   localparam logic [AMT_W-1:0] L_HI = AMT_W'(DENOM_HI);
   localparam logic [AMT_W-1:0] L_LO = AMT_W'(DENOM_LO);
   localparam logic [CNT_W:0]   L_MAX = (CNT_W+1)'(MAX_NOTES);

   phase_t           r_phase;
   logic [AMT_W-1:0] r_rem;
   logic [CNT_W-1:0] r_lvl_hi, r_lvl_lo, r_plan_hi, r_plan_lo;
   logic [CNT_W:0]   w_total;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phase   <= P_IDLE;
         r_rem     <= '0;
         r_lvl_hi  <= '0;
         r_lvl_lo  <= '0;
         r_plan_hi <= '0;
         r_plan_lo <= '0;
      end else if (i_clear) begin
         r_phase <= P_IDLE;
      end else if (i_start) begin
         r_rem     <= i_amount;
         r_lvl_hi  <= i_lvl_hi;
         r_lvl_lo  <= i_lvl_lo;
         r_plan_hi <= '0;
         r_plan_lo <= '0;
         r_phase   <= P_HI;
      end else begin
         // Compare before subtract so the remainder never wraps.
         case (r_phase)
            P_HI: if (r_rem >= L_HI && r_plan_hi < r_lvl_hi) begin
                     r_rem     <= r_rem - L_HI;
                     r_plan_hi <= r_plan_hi + 1'b1;
                  end else begin
                     r_phase <= P_LO;
                  end
            P_LO: if (r_rem >= L_LO && r_plan_lo < r_lvl_lo) begin
                     r_rem     <= r_rem - L_LO;
                     r_plan_lo <= r_plan_lo + 1'b1;
                  end else begin
                     r_phase <= P_CHECK;
                  end
            P_CHECK: r_phase <= P_IDLE;
            default: r_phase <= P_IDLE;
         endcase
      end
   end

   assign w_total = {1'b0, r_plan_hi} + {1'b0, r_plan_lo};

   always_comb begin
      o_plan_status = ST_OK;
      if ((r_rem % L_LO) != '0)  o_plan_status = ST_BAD_AMOUNT;
      else if (r_rem != '0)      o_plan_status = ST_INSUFFICIENT;
      else if (w_total > L_MAX)  o_plan_status = ST_TOO_MANY;
   end

   assign o_plan_done = (r_phase == P_CHECK);
   assign o_plan_hi   = r_plan_hi;
   assign o_plan_lo   = r_plan_lo;
endmodule

// File: rtl/atm_dispense_sequencer.sv
// Dispense sequencer: accepts a withdrawal, plans the note mix, then picks one note at a time and
// waits for the exit sensor. `define DISPENSE_RETRY_EN re-picks once after a first sensor timeout.
module atm_dispense_sequencer
   import atm_dispense_pkg::*;
#(
   parameter int AMT_W     = 16,
   parameter int CNT_W     = 8,
   parameter int DENOM_HI  = 500,
   parameter int DENOM_LO  = 100,
   parameter int MAX_NOTES = 40,
   parameter int TIMEOUT   = 255
) (
   input logic                     i_clk,
   input logic                     i_rst_n,
   atm_dispense_sequencer_if.slave ctl
);
   localparam int             TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           r_state;
   status_t          r_status;
   logic [CNT_W-1:0] r_notes_hi, r_notes_lo, r_left_hi, r_left_lo;
   logic [TW-1:0]    r_timer;
   logic             r_cur_hi, r_abort_pend;

   logic             w_accept, w_start, w_clear, w_plan_done, w_abort_any;
   logic             w_timeout, w_last, w_retry, w_sense;
   logic [CNT_W-1:0] w_plan_hi, w_plan_lo;
   status_t          w_plan_status;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_accept    = (r_state == S_IDLE) && ctl.req_valid;
   assign w_start     = w_accept && (ctl.req_amount != '0);
   assign w_clear     = (r_state == S_PLAN) && ctl.abort;
   assign w_abort_any = r_abort_pend || ctl.abort;
   assign w_sense     = (r_state == S_WAIT) && ctl.note_sensed;
   assign w_timeout   = (r_state == S_WAIT) && !ctl.note_sensed && (r_timer == TMO_LAST);
   assign w_last      = r_cur_hi ? (r_left_hi == ONE && r_left_lo == '0) : (r_left_lo == ONE);

   atm_note_planner #(
      .AMT_W(AMT_W), .CNT_W(CNT_W), .DENOM_HI(DENOM_HI), .DENOM_LO(DENOM_LO), .MAX_NOTES(MAX_NOTES)
   ) u_planner (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_start      (w_start),
      .i_clear      (w_clear),
      .i_amount     (ctl.req_amount),
      .i_lvl_hi     (ctl.cass_hi_level),
      .i_lvl_lo     (ctl.cass_lo_level),
      .o_plan_hi    (w_plan_hi),
      .o_plan_lo    (w_plan_lo),
      .o_plan_done  (w_plan_done),
      .o_plan_status(w_plan_status)
   );

`ifdef DISPENSE_RETRY_EN
   logic r_retried;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                   r_retried <= 1'b0;
      else if (w_accept || w_sense)   r_retried <= 1'b0;
      else if (w_timeout)             r_retried <= 1'b1;
   end
   // A pending abort turns the first timeout straight into JAM rather than a second pick.
   assign w_retry = !r_retried && !w_abort_any;
`else
   assign w_retry = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_status     <= ST_OK;
         r_notes_hi   <= '0;
         r_notes_lo   <= '0;
         r_left_hi    <= '0;
         r_left_lo    <= '0;
         r_timer      <= '0;
         r_cur_hi     <= 1'b0;
         r_abort_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (ctl.req_valid) begin
               r_notes_hi   <= '0;
               r_notes_lo   <= '0;
               r_status     <= ST_OK;
               r_abort_pend <= 1'b0;
               if (ctl.req_amount == '0) begin
                  r_status <= ST_BAD_AMOUNT;
                  r_state  <= S_DONE;
               end else begin
                  r_state <= S_PLAN;
               end
            end
            S_PLAN: if (ctl.abort) begin
               r_status <= ST_ABORTED;
               r_state  <= S_DONE;
            end else if (w_plan_done) begin
               if (w_plan_status == ST_OK) begin
                  r_left_hi <= w_plan_hi;
                  r_left_lo <= w_plan_lo;
                  r_state   <= S_PICK;
               end else begin
                  r_status <= w_plan_status;
                  r_state  <= S_ERR;
               end
            end
            S_PICK: if (ctl.abort) begin
               r_status <= ST_ABORTED;
               r_state  <= S_DONE;
            end else begin
               r_cur_hi <= (r_left_hi != '0);
               r_timer  <= '0;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               r_timer <= r_timer + 1'b1;
               // A sense on the last timeout cycle still counts as delivered.
               if (ctl.note_sensed) begin
                  if (r_cur_hi) begin
                     r_left_hi  <= r_left_hi - 1'b1;
                     r_notes_hi <= sat_inc(r_notes_hi);
                  end else begin
                     r_left_lo  <= r_left_lo - 1'b1;
                     r_notes_lo <= sat_inc(r_notes_lo);
                  end
                  if (w_abort_any) begin
                     r_status <= ST_ABORTED;
                     r_state  <= S_DONE;
                  end else if (w_last) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_PICK;
                  end
               end else if (w_timeout) begin
                  if (w_retry) begin
                     r_state <= S_PICK;
                  end else begin
                     r_status <= ST_JAM;
                     r_state  <= S_ERR;
                  end
               end else if (ctl.abort) begin
                  r_abort_pend <= 1'b1;
               end
            end
            S_ERR:   r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ctl.req_ready = (r_state == S_IDLE);
   assign ctl.busy      = (r_state != S_IDLE);
   assign ctl.done      = (r_state == S_DONE);
   assign ctl.pick_hi   = (r_state == S_PICK) && !ctl.abort && (r_left_hi != '0);
   assign ctl.pick_lo   = (r_state == S_PICK) && !ctl.abort && (r_left_hi == '0) && (r_left_lo != '0);
   assign ctl.status    = r_status;
   assign ctl.notes_hi  = r_notes_hi;
   assign ctl.notes_lo  = r_notes_lo;
endmodule
